// File: rtl/fft_frame_loader.sv
// -----------------------------------------------------------------------------
// fft_frame_loader
//
// Front-end writer for the in-place radix-2 butterfly engine. Complex samples
// arrive one per cycle over a valid/ready stream. Each sample is stored at the
// bit-reversed position of its arrival index, so the engine receives its input
// already in bit-reversed order. After the last sample of a frame, the loader
// issues a one-cycle start pulse. It then refuses input for the engine's fixed
// compute time and reopens for the next frame.
//
// Ports
//   clk        in   rising-edge clock for all state
//   rst        in   synchronous, active-high reset (wins over everything)
//   in_valid   in   a sample is present on in_Re/in_Im
//   in_Re      in   [15:0] real part of the sample
//   in_Im      in   [15:0] imaginary part of the sample
//   in_ready   out  loader accepts a sample this cycle (registered)
//   abort      in   drop the partial frame, or cancel the compute wait
//   start      out  one-cycle pulse to the engine; frame arrays are valid
//   busy       out  high while in START or COMPUTE
//   frame_Re   out  [16*D_WIDTH-1:0] real frame; entry k is bits [16*k +: 16]
//   frame_Im   out  [16*D_WIDTH-1:0] imaginary frame, same packing
//
// The frame outputs come straight from the buffer registers. The buffer is
// written only on accepts in FILL. Therefore the arrays hold still from the
// last accept through START and COMPUTE. start, busy and in_ready are decodes
// of registered state. Their timing does not depend on in_valid in the
// current cycle.
// -----------------------------------------------------------------------------
module fft_frame_loader #(
    parameter int D_WIDTH        = 64,   // points per frame, power of two
    parameter int LOG_2_WIDTH    = 6,    // log2(D_WIDTH)
    parameter int COMPUTE_CYCLES = 192   // engine busy clocks after start, >= 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [15:0]              in_Re,
    input  logic [15:0]              in_Im,
    output logic                     in_ready,
    input  logic                     abort,
    output logic                     start,
    output logic                     busy,
    output logic [16*D_WIDTH-1:0]    frame_Re,
    output logic [16*D_WIDTH-1:0]    frame_Im
);

    // The wait counter needs to hold COMPUTE_CYCLES-1. Keep it at least
    // one bit wide so that COMPUTE_CYCLES == 1 still elaborates.
    localparam int WAIT_W = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;

    localparam logic [LOG_2_WIDTH-1:0] LAST_CNT  = LOG_2_WIDTH'(D_WIDTH - 1);
    localparam logic [WAIT_W-1:0]      WAIT_LOAD = WAIT_W'(COMPUTE_CYCLES - 1);

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        START   = 2'd1,
        COMPUTE = 2'd2
    } state_e;

    // ------------------------------------------------------------------------
    // Registers and next-state signals
    // ------------------------------------------------------------------------
    state_e                   state_q, state_d;
    logic [LOG_2_WIDTH-1:0]   cnt_q,   cnt_d;
    logic [WAIT_W-1:0]        wait_q,  wait_d;
    logic                     in_ready_q, in_ready_d;

    logic                     wr_en;
    logic [LOG_2_WIDTH-1:0]   wr_idx;

    logic [15:0]              re_q [D_WIDTH];
    logic [15:0]              im_q [D_WIDTH];

    // Mirror the LOG_2_WIDTH bits of the arrival index. For example,
    // index 1 maps to D_WIDTH/2.
    function automatic logic [LOG_2_WIDTH-1:0] bitrev(input logic [LOG_2_WIDTH-1:0] v);
        logic [LOG_2_WIDTH-1:0] r;
        r = '0;
        for (int b = 0; b < LOG_2_WIDTH; b++) begin
            r[b] = v[LOG_2_WIDTH-1-b];
        end
        return r;
    endfunction

    assign wr_idx = bitrev(cnt_q);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    // NOTE: every signal assigned here gets a default value first. Without
    // the defaults, any path that skips an assignment would infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        wr_en   = 1'b0;

        unique case (state_q)
            FILL: begin
                if (abort) begin
                    // If a sample arrives in the same cycle, it is dropped.
                    // The old buffer contents stay; the next frame overwrites them.
                    cnt_d = '0;
                end else if (in_valid && in_ready_q) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + LOG_2_WIDTH'(1);   // wraps to 0 after the last sample
                    if (cnt_q == LAST_CNT) begin
                        state_d = START;
                    end
                end
            end

            START: begin
                // start is already high this cycle. abort only changes the
                // next state.
                if (abort) begin
                    state_d = FILL;
                end else begin
                    state_d = COMPUTE;
                    wait_d  = WAIT_LOAD;
                end
            end

            COMPUTE: begin
                if (abort) begin
                    state_d = FILL;
                    cnt_d   = '0;
                end else if (wait_q == '0) begin
                    state_d = FILL;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end

            default: begin
                state_d = FILL;
                cnt_d   = '0;
                wait_d  = '0;
            end
        endcase

        // Register in_ready with the state. It then follows the FILL state
        // without a cycle of lag, and it is low in the cycle after reset.
        in_ready_d = (state_d == FILL);
    end

    // ------------------------------------------------------------------------
    // Control state register
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments. All registers
    // then update together at the edge, regardless of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FILL;
            cnt_q      <= '0;
            wait_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wait_q     <= wait_d;
            in_ready_q <= in_ready_d;
        end
    end

    // ------------------------------------------------------------------------
    // Frame buffer
    // ------------------------------------------------------------------------
    // NOTE: this buffer is reset on purpose. A reset must present an all-zero
    // frame to the engine, so the buffer is built as flops, not RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < D_WIDTH; i++) begin
                re_q[i] <= '0;
                im_q[i] <= '0;
            end
        end else if (wr_en) begin
            re_q[wr_idx] <= in_Re;
            im_q[wr_idx] <= in_Im;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    for (genvar g = 0; g < D_WIDTH; g++) begin : g_pack
        assign frame_Re[16*g +: 16] = re_q[g];
        assign frame_Im[16*g +: 16] = im_q[g];
    end

    assign in_ready = in_ready_q;
    assign start    = (state_q == START);
    assign busy     = (state_q == START) || (state_q == COMPUTE);

endmodule
